seq_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider; the inverse operation to the team's 4-bit array multiplier.
- Given dividend and divisor, produces quotient and remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath, with a start/done handshake so a controller can issue back-to-back operations.
- Verification can close the loop: multiplier(quotient, divisor) + remainder == dividend.

---
 rtl/seq_restoring_divider_if.sv | 23 ++
 rtl/seq_restoring_divider.sv | 97 +++++++++
 tb/tb_seq_restoring_divider.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake,
// divide-by-zero resolved on the accepting edge.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_restoring_divider_if.slave bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, CALC} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  // One restoring step; the kept partial remainder is always < divisor, so WIDTH bits suffice.
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   d_ext;
  logic             ge;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    p_shift = {p_q, q_q[WIDTH-1]};
    d_ext   = {1'b0, d_q};
    ge      = (p_shift >= d_ext);
    p_next  = ge ? WIDTH'(p_shift - d_ext) : p_shift[WIDTH-1:0];
    q_shift = q_q << 1;
    q_next  = {q_shift[WIDTH-1:1], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quot_q <= '1;
              rem_q  <= bus.dividend;
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              d_q     <= bus.divisor;
              q_q     <= bus.dividend;
              p_q     <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          p_q   <= p_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_q  <= q_next;
            rem_q   <= p_next;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against an arithmetic reference model.
module tb_seq_restoring_divider;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [WIDTH-1:0] prev_q, prev_r;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mul(input int a, input int b);
    return a * b;
  endfunction

  // Runs one operation; ignored_at > 0 re-pulses start with junk operands that many cycles in.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int ignored_at, input bit keep_start);
    int cyc;
    int exp_lat;
    logic [WIDTH-1:0] eq, er;
    if (b == 0) begin eq = '1; er = a; exp_lat = 0; end
    else begin eq = WIDTH'(int'(a) / int'(b)); er = WIDTH'(int'(a) % int'(b)); exp_lat = WIDTH; end
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    if (!keep_start) bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      check($sformatf("busy_%0d_%0d_c%0d", a, b, cyc), 32'(bus.busy), 32'(1));
      check($sformatf("hold_q_%0d_%0d_c%0d", a, b, cyc), 32'(bus.quotient), 32'(prev_q));
      if (ignored_at > 0 && cyc == ignored_at - 1) begin
        bus.dividend = 4'd8;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
      end else if (!keep_start) begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    check($sformatf("done_seen_%0d_%0d", a, b), 32'(bus.done), 32'(1));
    check($sformatf("latency_%0d_%0d", a, b), 32'(cyc), 32'(exp_lat));
    check($sformatf("busy_at_done_%0d_%0d", a, b), 32'(bus.busy), 32'(0));
    check($sformatf("quot_%0d_%0d", a, b), 32'(bus.quotient), 32'(eq));
    check($sformatf("rem_%0d_%0d", a, b), 32'(bus.remainder), 32'(er));
    check($sformatf("dbz_%0d_%0d", a, b), 32'(bus.div_by_zero), 32'(b == 0));
    if (b != 0) begin
      check($sformatf("mul_loop_%0d_%0d", a, b),
            32'(mul(int'(bus.quotient), int'(b)) + int'(bus.remainder)), 32'(a));
      check($sformatf("rem_lt_div_%0d_%0d", a, b), 32'(bus.remainder < b), 32'(1));
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done) pulses++;
      tick();
    end
    check(tag, 32'(pulses), 32'(0));
  endtask

  initial begin
    int a_r, b_r;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    prev_q       = '0;
    prev_r       = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_q", 32'(bus.quotient), 32'(0));
    check("rst_r", 32'(bus.remainder), 32'(0));
    check("rst_dbz", 32'(bus.div_by_zero), 32'(0));
    rst = 1'b0;
    tick();

    run_op(4'd13, 4'd3, 0, 1'b0);
    check("done_one_cycle", 32'(bus.done), 32'(1));
    tick();
    check("done_cleared", 32'(bus.done), 32'(0));

    run_op(4'd15, 4'd1, 0, 1'b0);  tick();
    run_op(4'd5, 4'd7, 0, 1'b0);   tick();
    run_op(4'd15, 4'd15, 0, 1'b0); tick();
    run_op(4'd0, 4'd9, 0, 1'b0);   tick();

    run_op(4'd9, 4'd0, 0, 1'b0);
    tick();
    check("dbz_done_cleared", 32'(bus.done), 32'(0));
    check("dbz_busy_after", 32'(bus.busy), 32'(0));
    check("dbz_held", 32'(bus.div_by_zero), 32'(1));
    run_op(4'd6, 4'd2, 0, 1'b0);   tick();

    run_op(4'd13, 4'd3, 2, 1'b0);
    tick();
    expect_quiet("no_extra_done", 8);

    // Asynchronous reset between clock edges, two cycles into a calculation.
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_done", 32'(bus.done), 32'(0));
    check("arst_q", 32'(bus.quotient), 32'(0));
    check("arst_r", 32'(bus.remainder), 32'(0));
    check("arst_dbz", 32'(bus.div_by_zero), 32'(0));
    tick();
    rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    expect_quiet("arst_no_done", 8);
    run_op(4'd10, 4'd4, 0, 1'b0);
    tick();

    // Back-to-back with start held high over every operand pair.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(WIDTH'(a), WIDTH'(b), 0, 1'b1);
      end
    end
    bus.start = 1'b0;
    tick();
    tick();
    check("b2b_idle_done", 32'(bus.done), 32'(0));

    // A few random operations, including random gaps between them.
    for (int i = 0; i < 20; i++) begin
      a_r = int'($urandom_range(15, 0));
      b_r = int'($urandom_range(15, 0));
      run_op(WIDTH'(a_r), WIDTH'(b_r), 0, 1'b0);
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
